// File: rtl/fas_pkg.sv
// Shared definitions for the FAS datapath (FIR -> frame buffer -> FFT).
//   FIR_W        : FIR sample width (signed two's complement)
//   FRAME_N      : samples per frame handed to the FFT
//   fir_sample_t : one signed FIR sample
package fas_pkg;

  localparam int unsigned FIR_W   = 16;
  localparam int unsigned FRAME_N = 16;

  typedef logic signed [FIR_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_frame_bank.sv
// One N x W sample bank of the ping-pong frame buffer.
//   clk, rst_n : clock, asynchronous active-low reset (clears every sample)
//   we_i       : write d_i into slot idx_i on the rising edge
//   idx_i      : slot index, 0..N-1
//   d_i        : sample to store
//   data_o     : whole bank, slot k at bits [k*W +: W]
module fir_frame_bank
  import fas_pkg::*;
#(
  parameter int unsigned N = FRAME_N,
  parameter int unsigned W = FIR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] idx_i,
  input  logic [W-1:0]         d_i,
  output logic [N*W-1:0]       data_o
);

  logic [N*W-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[idx_i*W +: W] <= d_i;
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/fir_frame_buf.sv
// Ping-pong frame collector between the FIR filter and the FFT.
//   clk, rst_n  : clock, asynchronous active-low reset
//   fir_valid   : fir_d carries a valid sample this cycle
//   fir_d       : signed FIR sample
//   frame_ready : downstream accepts the presented frame this cycle
//   frame_valid : frame_d holds a complete frame
//   frame_d     : sample k at bits [k*W +: W], k=0 oldest
//   frame_id    : sequence number of the presented frame (mod 256)
//   ovf         : sticky, a sample was dropped because both banks were full
module fir_frame_buf
  import fas_pkg::*;
#(
  parameter int unsigned N = FRAME_N,
  parameter int unsigned W = FIR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fir_valid,
  input  logic signed [W-1:0] fir_d,
  input  logic                frame_ready,
  output logic                frame_valid,
  output logic [N*W-1:0]      frame_d,
  output logic [7:0]          frame_id,
  output logic                ovf
);

  localparam int unsigned   IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0]  widx_q, widx_d;
  logic           wbank_q, wbank_d;
  logic           rbank_q, rbank_d;
  logic [1:0]     full_q, full_d;
  logic [7:0]     id_q, id_d;
  logic           ovf_q, ovf_d;

  logic           wr, hs;
  logic           we0, we1;
  logic [N*W-1:0] bank0_data, bank1_data;

  // Both decisions use pre-edge state: a bank released this cycle is not
  // yet free for the writer, so a sample aimed at it is dropped.
  assign wr = fir_valid && !full_q[wbank_q];
  assign hs = full_q[rbank_q] && frame_ready;

  always_comb begin
    widx_d  = widx_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    id_d    = id_q;
    ovf_d   = ovf_q;

    if (hs) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      id_d            = id_q + 8'd1;
    end

    // The writer only targets a non-full bank and the reader only a full
    // one, so a completion here never collides with the release above.
    if (wr) begin
      widx_d = widx_q + 1'b1;
      if (widx_q == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end else if (fir_valid) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      widx_q  <= widx_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
    end
  end

  assign we0 = wr && !wbank_q;
  assign we1 = wr &&  wbank_q;

  fir_frame_bank #(.N(N), .W(W)) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we0),
    .idx_i  (widx_q),
    .d_i    (fir_d),
    .data_o (bank0_data)
  );

  fir_frame_bank #(.N(N), .W(W)) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we1),
    .idx_i  (widx_q),
    .d_i    (fir_d),
    .data_o (bank1_data)
  );

  assign frame_valid = full_q[rbank_q];
  assign frame_d     = rbank_q ? bank1_data : bank0_data;
  assign frame_id    = id_q;
  assign ovf         = ovf_q;

endmodule
